yj_basic_input_debounce: RTL and testbench



---
 rtl/yj_basic_input_debounce_pkg.sv | 20 ++
 rtl/yj_basic_input_debounce_if.sv | 36 +++
 rtl/yj_basic_debounce_bit.sv | 81 ++++++++
 rtl/yj_basic_input_debounce.sv | 55 +++++
 tb/tb_yj_basic_input_debounce.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/yj_basic_input_debounce_pkg.sv
// -----------------------------------------------------------------------------
// yj_basic_input_debounce_pkg
// Shared defaults and the CNT_MAX legality check for the basic input debounce
// element and its per-bit sub-module.
// No ports (package).
// -----------------------------------------------------------------------------
package yj_basic_input_debounce_pkg;

  localparam int DW_DEFAULT      = 8;
  localparam int CNT_W_DEFAULT   = 16;
  localparam int CNT_MAX_DEFAULT = 1000;
  localparam bit RSTVAL_DEFAULT  = 1'b0;

  // CNT_MAX is legal in 1 .. 2^cnt_w; the upper bound makes CNT_MAX-1 the
  // all-ones counter value, so the counter never needs to wrap.
  function automatic bit cnt_max_legal(input int cnt_w, input longint cnt_max);
    return (cnt_max >= 64'sd1) && (cnt_max <= (64'sd1 <<< cnt_w));
  endfunction

endpackage

// File: rtl/yj_basic_input_debounce_if.sv
// -----------------------------------------------------------------------------
// yj_basic_input_debounce_if
// Bundles the debouncer's data-side signals.
//   din      : synchronized input levels      (master -> slave)
//   en       : sample tick                    (master -> slave)
//   evt_clr  : per-bit clear of evt_pend      (master -> slave)
//   dout     : debounced levels               (slave -> master)
//   rise     : one-cycle 0->1 pulses          (slave -> master)
//   fall     : one-cycle 1->0 pulses          (slave -> master)
//   evt_pend : sticky edge flags              (slave -> master)
// -----------------------------------------------------------------------------
interface yj_basic_input_debounce_if
  import yj_basic_input_debounce_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic [DW-1:0] din;
  logic          en;
  logic [DW-1:0] evt_clr;
  logic [DW-1:0] dout;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic [DW-1:0] evt_pend;

  modport master (
    output din, en, evt_clr,
    input  dout, rise, fall, evt_pend
  );

  modport slave (
    input  din, en, evt_clr,
    output dout, rise, fall, evt_pend
  );

endinterface

// File: rtl/yj_basic_debounce_bit.sv
// -----------------------------------------------------------------------------
// yj_basic_debounce_bit
// One bit of the debouncer: stability counter, accepted level, registered
// rise/fall pulses and sticky event flag.
//   CLK      : clock, all state on posedge
//   RST      : synchronous active-high reset
//   din      : synchronized input level
//   en       : sample tick
//   evt_clr  : clear for evt_pend (loses to a simultaneous accept)
//   dout     : debounced level
//   rise     : one-cycle pulse in the first cycle dout shows 1
//   fall     : one-cycle pulse in the first cycle dout shows 0
//   evt_pend : sticky flag, set by any accepted edge
// -----------------------------------------------------------------------------
module yj_basic_debounce_bit
  import yj_basic_input_debounce_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int CNT_MAX = CNT_MAX_DEFAULT,
  parameter bit RSTVAL  = RSTVAL_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  input  logic en,
  input  logic evt_clr,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic evt_pend
);

  if (!cnt_max_legal(CNT_W, CNT_MAX)) begin : g_bad_cnt_max
    $error("yj_basic_debounce_bit: CNT_MAX=%0d outside 1..2^%0d", CNT_MAX, CNT_W);
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             accept;

  assign differs = (din != dout);
  // The new level has held for CNT_MAX qualifying samples including this one.
  assign accept  = differs && en && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: reset is synchronous; RST is only looked at on the clock edge
      // and overrides every other input, discarding any count in progress.
      cnt      <= '0;
      dout     <= RSTVAL;
      rise     <= 1'b0;
      fall     <= 1'b0;
      evt_pend <= 1'b0;
    end else begin
      rise <= accept &&  din;
      fall <= accept && !din;

      if (!differs) begin
        // Level agrees with the accepted value: any glitch progress is dropped.
        cnt <= '0;
      end else if (accept) begin
        dout <= din;
        cnt  <= '0;
      end else if (en) begin
        cnt <= cnt + CNT_W'(1);
      end

      // Set wins over clear so an edge landing on a clear is never lost.
      if (accept) begin
        evt_pend <= 1'b1;
      end else if (evt_clr) begin
        evt_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/yj_basic_input_debounce.sv
// -----------------------------------------------------------------------------
// yj_basic_input_debounce
// DW independent debouncers / edge detectors for already-synchronized slow
// inputs (buttons, limit switches, strobes). All outputs are registered.
//   CLK : clock, all state on posedge
//   RST : synchronous active-high reset
//   bus : slave side of yj_basic_input_debounce_if
//         (din, en, evt_clr in; dout, rise, fall, evt_pend out)
// -----------------------------------------------------------------------------
module yj_basic_input_debounce
  import yj_basic_input_debounce_pkg::*;
#(
  parameter int DW      = DW_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT,
  parameter int CNT_MAX = CNT_MAX_DEFAULT,
  parameter bit RSTVAL  = RSTVAL_DEFAULT
) (
  input logic                      CLK,
  input logic                      RST,
  yj_basic_input_debounce_if.slave bus
);

  if (!cnt_max_legal(CNT_W, CNT_MAX)) begin : g_bad_cnt_max
    $error("yj_basic_input_debounce: CNT_MAX=%0d outside 1..2^%0d", CNT_MAX, CNT_W);
  end

  logic [DW-1:0] dout;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic [DW-1:0] evt_pend;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    yj_basic_debounce_bit #(
      .CNT_W   (CNT_W),
      .CNT_MAX (CNT_MAX),
      .RSTVAL  (RSTVAL)
    ) u_bit (
      .CLK      (CLK),
      .RST      (RST),
      .din      (bus.din[i]),
      .en       (bus.en),
      .evt_clr  (bus.evt_clr[i]),
      .dout     (dout[i]),
      .rise     (rise[i]),
      .fall     (fall[i]),
      .evt_pend (evt_pend[i])
    );
  end

  assign bus.dout     = dout;
  assign bus.rise     = rise;
  assign bus.fall     = fall;
  assign bus.evt_pend = evt_pend;

endmodule

// File: tb/tb_yj_basic_input_debounce.sv
// -----------------------------------------------------------------------------
// tb_yj_basic_input_debounce
// Directed bench: DW=2, CNT_W=4, CNT_MAX=4. Instance u_a uses RSTVAL=0,
// instance u_b uses RSTVAL=1. Inputs change 1 ns after a posedge; outputs are
// sampled at the same point, i.e. after the edge just taken.
// -----------------------------------------------------------------------------
module tb_yj_basic_input_debounce;

  logic CLK = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 CLK = ~CLK;

  yj_basic_input_debounce_if #(.DW(2)) bus_a ();
  yj_basic_input_debounce_if #(.DW(2)) bus_b ();

  yj_basic_input_debounce #(
    .DW(2), .CNT_W(4), .CNT_MAX(4), .RSTVAL(1'b0)
  ) u_a (
    .CLK (CLK),
    .RST (rst_a),
    .bus (bus_a)
  );

  yj_basic_input_debounce #(
    .DW(2), .CNT_W(4), .CNT_MAX(4), .RSTVAL(1'b1)
  ) u_b (
    .CLK (CLK),
    .RST (rst_b),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %b, expected %b", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Compare all four outputs of instance u_a.
  task automatic check_a(input string tag, input logic [1:0] dout, input logic [1:0] rise,
                         input logic [1:0] fall, input logic [1:0] pend);
    check({tag, ".dout"}, bus_a.dout, dout);
    check({tag, ".rise"}, bus_a.rise, rise);
    check({tag, ".fall"}, bus_a.fall, fall);
    check({tag, ".pend"}, bus_a.evt_pend, pend);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.din = 2'b00; bus_a.en = 1'b1; bus_a.evt_clr = 2'b00;
    bus_b.din = 2'b11; bus_b.en = 1'b1; bus_b.evt_clr = 2'b00;
    step();
    step();
    check_a("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    check("reset_b.dout", bus_b.dout, 2'b11);

    // Quiet input: nothing moves.
    rst_a = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      check_a("quiet", 2'b00, 2'b00, 2'b00, 2'b00);
    end

    // Bit 0 rises: accepted on the 4th edge, pulse lasts one cycle.
    bus_a.din = 2'b01;
    for (int j = 1; j <= 3; j++) begin
      step();
      check_a("rise_wait", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    step();
    check_a("rise_acc", 2'b01, 2'b01, 2'b00, 2'b01);
    step();
    check_a("rise_after", 2'b01, 2'b00, 2'b00, 2'b01);
    step();
    check_a("pend_sticky", 2'b01, 2'b00, 2'b00, 2'b01);

    // Bit 1 glitches high for 3 cycles, twice: never accepted.
    for (int g = 0; g < 2; g++) begin
      bus_a.din = 2'b11;
      for (int j = 0; j < 3; j++) begin
        step();
        check_a("glitch_hi", 2'b01, 2'b00, 2'b00, 2'b01);
      end
      bus_a.din = 2'b01;
      step();
      check_a("glitch_lo", 2'b01, 2'b00, 2'b00, 2'b01);
    end
    // Counter restarted from 0: a full 4 cycles are needed again.
    bus_a.din = 2'b11;
    for (int j = 0; j < 3; j++) begin
      step();
      check_a("post_glitch_wait", 2'b01, 2'b00, 2'b00, 2'b01);
    end
    step();
    check_a("post_glitch_acc", 2'b11, 2'b10, 2'b00, 2'b11);

    // Clear both flags, no edge in progress.
    bus_a.evt_clr = 2'b11;
    step();
    check_a("clr_all", 2'b11, 2'b00, 2'b00, 2'b00);
    bus_a.evt_clr = 2'b00;

    // en high one edge in three; bit 0 falls on the 4th en-high edge.
    bus_a.din = 2'b10;
    for (int j = 0; j < 12; j++) begin
      bus_a.en = (j % 3 == 0);
      step();
      if (j < 9)
        check_a("slow_en_wait", 2'b11, 2'b00, 2'b00, 2'b00);
      else if (j == 9)
        check_a("slow_en_acc", 2'b10, 2'b00, 2'b01, 2'b01);
      else
        check_a("slow_en_after", 2'b10, 2'b00, 2'b00, 2'b01);
    end
    bus_a.en = 1'b1;

    // Clear coincident with accept: set wins; a later lone clear takes effect.
    bus_a.evt_clr = 2'b01;
    step();
    check_a("pre_clr", 2'b10, 2'b00, 2'b00, 2'b00);
    bus_a.evt_clr = 2'b00;
    bus_a.din = 2'b11;
    for (int j = 0; j < 3; j++) step();
    bus_a.evt_clr = 2'b01;
    step();
    check_a("set_wins", 2'b11, 2'b01, 2'b00, 2'b01);
    step();
    check_a("late_clr", 2'b11, 2'b00, 2'b00, 2'b00);
    bus_a.evt_clr = 2'b00;

    // Bring both bits low, then start bit 0 rising and reset mid-count.
    bus_a.din = 2'b00;
    for (int j = 0; j < 4; j++) step();
    check_a("both_low", 2'b00, 2'b00, 2'b11, 2'b11);
    bus_a.evt_clr = 2'b11;
    step();
    bus_a.evt_clr = 2'b00;
    bus_a.din = 2'b01;
    step();
    step();
    check_a("mid_count", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_a = 1'b1;
    step();
    check_a("mid_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    rst_a = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check_a("restart_wait", 2'b00, 2'b00, 2'b00, 2'b00);
    end
    step();
    check_a("restart_acc", 2'b01, 2'b01, 2'b00, 2'b01);

    // RSTVAL=1 instance: reset level, hold, then a debounced fall.
    rst_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("b_hold.dout", bus_b.dout, 2'b11);
      check("b_hold.fall", bus_b.fall, 2'b00);
    end
    bus_b.din = 2'b00;
    step();
    step();
    rst_b = 1'b1;
    step();
    check("b_reset.dout", bus_b.dout, 2'b11);
    check("b_reset.pend", bus_b.evt_pend, 2'b00);
    rst_b = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("b_wait.dout", bus_b.dout, 2'b11);
    end
    step();
    check("b_acc.dout", bus_b.dout, 2'b00);
    check("b_acc.fall", bus_b.fall, 2'b11);
    check("b_acc.rise", bus_b.rise, 2'b00);
    check("b_acc.pend", bus_b.evt_pend, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
